// File: rtl/posit_pkg.sv
// Shared definitions for the posit datapath: rounding-mode codes, the
// round-unit FSM state type and the default regime ceiling (maxpos).
package posit_pkg;

  localparam logic [1:0] RND_RNE = 2'b00;
  localparam logic [1:0] RND_RTZ = 2'b01;
  localparam logic [1:0] RND_RAZ = 2'b10;

  // Largest legal regime value; the regime encoder uses the same default.
  localparam int K_MAX_DEFAULT = 26;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ROUND,
    ST_NORM,
    ST_DONE
  } state_t;

endpackage

// File: rtl/round_incr.sv
// Combinational rounding increment: splits the discarded tail into guard
// and sticky bits, decides the increment for the selected mode, and adds
// it to the kept bits with the carry-out preserved in sum[FRAC_W].
module round_incr
  import posit_pkg::*;
#(
  parameter int IN_W   = 64,
  parameter int FRAC_W = 32
) (
  input  logic [FRAC_W-1:0]      kept,
  input  logic [IN_W-FRAC_W-1:0] tail,
  input  logic [1:0]             mode,
  output logic [FRAC_W:0]        sum,
  output logic                   inexact
);

  localparam int TAIL_W = IN_W - FRAC_W;

  logic g;
  logic s;
  logic inc;

  assign g = tail[TAIL_W-1];
  assign s = |tail[TAIL_W-2:0];

  // Increment decision; the unused mode code falls back to round-to-nearest-even.
  always_comb begin
    // NOTE: default assignment first so every path drives inc and no latch is inferred.
    inc = 1'b0;
    case (mode)
      RND_RTZ: inc = 1'b0;
      RND_RAZ: inc = g | s;
      default: inc = g & (s | kept[0]);
    endcase
  end

  assign sum     = {1'b0, kept} + {{FRAC_W{1'b0}}, inc};
  assign inexact = g | s;

endmodule

// File: rtl/posit_round_unit.sv
// Posit rounding stage: captures the aligned mantissa and fields on start,
// rounds to FRAC_W bits (ROUND), folds a mantissa carry into exponent and
// regime with maxpos saturation (NORM), and presents the result with a
// one-cycle done pulse (DONE).
module posit_round_unit
  import posit_pkg::*;
#(
  parameter int IN_W   = 64,
  parameter int FRAC_W = 32,
  parameter int ES     = 3,
  parameter int KW     = 6,
  parameter int K_MAX  = K_MAX_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [1:0]           rnd_mode,
  input  logic [IN_W-1:0]      shifted_mantissa,
  input  logic [KW-1:0]        k_out,
  input  logic [ES-1:0]        exp_out,
  input  logic                 sign_out,
  output logic [FRAC_W-1:0]    mantissa_out,
  output logic [KW-1:0]        k_final,
  output logic [ES-1:0]        exp_final,
  output logic                 sign_final,
  output logic                 inexact,
  output logic                 sat,
  output logic                 busy,
  output logic                 done
);

  localparam int                     TAIL_W  = IN_W - FRAC_W;
  localparam logic signed [KW-1:0]   K_MAX_V = KW'(K_MAX);
  localparam logic [ES-1:0]          EXP_MAX = '1;

  state_t                  state;
  logic [IN_W-1:0]         sm_q;
  logic signed [KW-1:0]    k_q;
  logic [ES-1:0]           exp_q;
  logic                    sign_q;
  logic [1:0]              mode_q;
  logic [FRAC_W:0]         sum_q;
  logic                    inexact_q;

  logic [FRAC_W:0]         sum;
  logic                    rnd_inexact;

  logic [FRAC_W-1:0]       norm_mant;
  logic [ES-1:0]           norm_exp;
  logic signed [KW-1:0]    norm_k;
  logic                    norm_sat;

  round_incr #(
    .IN_W   (IN_W),
    .FRAC_W (FRAC_W)
  ) u_round_incr (
    .kept    (sm_q[IN_W-1 -: FRAC_W]),
    .tail    (sm_q[TAIL_W-1:0]),
    .mode    (mode_q),
    .sum     (sum),
    .inexact (rnd_inexact)
  );

  // Renormalise a mantissa carry into exponent/regime, clamping at maxpos.
  always_comb begin
    norm_mant = sum_q[FRAC_W-1:0];
    norm_exp  = exp_q;
    norm_k    = k_q;
    norm_sat  = 1'b0;
    if (sum_q[FRAC_W]) begin
      if (exp_q == EXP_MAX && k_q == K_MAX_V) begin
        norm_mant = '1;
        norm_exp  = EXP_MAX;
        norm_k    = K_MAX_V;
        norm_sat  = 1'b1;
      end else begin
        norm_mant = '0;
        norm_exp  = exp_q + 1'b1;
        if (exp_q == EXP_MAX) norm_k = k_q + KW'(1);
      end
    end
  end

  // Control FSM with operand capture, intermediate sum and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: datapath registers are reset too, so outputs read 0 after reset and nothing stale leaks out.
      state        <= ST_IDLE;
      sm_q         <= '0;
      k_q          <= '0;
      exp_q        <= '0;
      sign_q       <= 1'b0;
      mode_q       <= RND_RNE;
      sum_q        <= '0;
      inexact_q    <= 1'b0;
      mantissa_out <= '0;
      k_final      <= '0;
      exp_final    <= '0;
      sign_final   <= 1'b0;
      inexact      <= 1'b0;
      sat          <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      case (state)
        ST_IDLE, ST_DONE: begin
          done <= 1'b0;
          if (start) begin
            sm_q   <= shifted_mantissa;
            k_q    <= k_out;
            exp_q  <= exp_out;
            sign_q <= sign_out;
            mode_q <= rnd_mode;
            busy   <= 1'b1;
            state  <= ST_ROUND;
          end else begin
            state  <= ST_IDLE;
          end
        end
        ST_ROUND: begin
          sum_q     <= sum;
          inexact_q <= rnd_inexact;
          state     <= ST_NORM;
        end
        ST_NORM: begin
          mantissa_out <= norm_mant;
          k_final      <= norm_k;
          exp_final    <= norm_exp;
          sign_final   <= sign_q;
          inexact      <= inexact_q;
          sat          <= norm_sat;
          busy         <= 1'b0;
          done         <= 1'b1;
          state        <= ST_DONE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_posit_round_unit.sv
// Self-checking bench for posit_round_unit: directed cases plus randomized
// operands compared against an arithmetic reference model.
module tb_posit_round_unit;
  import posit_pkg::*;

  localparam int IN_W   = 64;
  localparam int FRAC_W = 32;
  localparam int ES     = 3;
  localparam int KW     = 6;
  localparam int K_MAX  = 26;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [1:0]        rnd_mode;
  logic [IN_W-1:0]   shifted_mantissa;
  logic [KW-1:0]     k_out;
  logic [ES-1:0]     exp_out;
  logic              sign_out;
  logic [FRAC_W-1:0] mantissa_out;
  logic [KW-1:0]     k_final;
  logic [ES-1:0]     exp_final;
  logic              sign_final;
  logic              inexact;
  logic              sat;
  logic              busy;
  logic              done;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    longint mant;
    int     k;
    int     e;
    bit     inx;
    bit     sat;
  } ref_t;

  posit_round_unit #(
    .IN_W(IN_W), .FRAC_W(FRAC_W), .ES(ES), .KW(KW), .K_MAX(K_MAX)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .rnd_mode         (rnd_mode),
    .shifted_mantissa (shifted_mantissa),
    .k_out            (k_out),
    .exp_out          (exp_out),
    .sign_out         (sign_out),
    .mantissa_out     (mantissa_out),
    .k_final          (k_final),
    .exp_final        (exp_final),
    .sign_final       (sign_final),
    .inexact          (inexact),
    .sat              (sat),
    .busy             (busy),
    .done             (done)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input longint got, input longint want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  // Reference: the value is kept + tail/2^TAIL_W; round it arithmetically,
  // and on carry bump the combined scale k*2^ES+exp, clamping past maxpos.
  function automatic ref_t model(input logic [63:0] sm, input int k, input int e,
                                 input logic [1:0] mode);
    ref_t            r;
    longint unsigned kept, rem, half;
    bit              up;
    int              scale;
    kept = sm >> (IN_W - FRAC_W);
    rem  = sm & ((64'd1 << (IN_W - FRAC_W)) - 1);
    half = 64'd1 << (IN_W - FRAC_W - 1);
    case (mode)
      RND_RTZ: up = 1'b0;
      RND_RAZ: up = (rem != 0);
      default: up = (rem > half) || (rem == half && (kept % 2) == 1);
    endcase
    r.inx = (rem != 0);
    r.sat = 1'b0;
    kept  = kept + (up ? 1 : 0);
    if (kept == (64'd1 << FRAC_W)) begin
      scale = k * (1 << ES) + e + 1;
      if (scale > K_MAX * (1 << ES) + (1 << ES) - 1) begin
        r.mant = (64'd1 << FRAC_W) - 1;
        r.k    = K_MAX;
        r.e    = (1 << ES) - 1;
        r.sat  = 1'b1;
      end else begin
        r.mant = 0;
        r.k    = scale >>> ES;
        r.e    = scale & ((1 << ES) - 1);
      end
    end else begin
      r.mant = longint'(kept);
      r.k    = k;
      r.e    = e;
    end
    return r;
  endfunction

  task automatic drive(input logic [63:0] sm_i, input int k_i, input int e_i,
                       input logic [1:0] m_i, input logic sg_i);
    shifted_mantissa = sm_i;
    k_out            = KW'(k_i);
    exp_out          = ES'(e_i);
    rnd_mode         = m_i;
    sign_out         = sg_i;
  endtask

  task automatic check_out(input string tag, input ref_t r, input logic sg_i);
    check({tag, " mantissa"}, longint'(mantissa_out), r.mant);
    check({tag, " k"},        longint'($signed(k_final)), longint'(r.k));
    check({tag, " exp"},      longint'(exp_final), longint'(r.e));
    check({tag, " sign"},     longint'(sign_final), longint'(sg_i));
    check({tag, " inexact"},  longint'(inexact), longint'(r.inx));
    check({tag, " sat"},      longint'(sat), longint'(r.sat));
  endtask

  task automatic check_zero(input string tag);
    check({tag, " mantissa"}, longint'(mantissa_out), 0);
    check({tag, " k"},        longint'(k_final), 0);
    check({tag, " exp"},      longint'(exp_final), 0);
    check({tag, " sign"},     longint'(sign_final), 0);
    check({tag, " inexact"},  longint'(inexact), 0);
    check({tag, " sat"},      longint'(sat), 0);
    check({tag, " busy"},     longint'(busy), 0);
    check({tag, " done"},     longint'(done), 0);
  endtask

  // One operation; disturb=1 pulses start with different operands while busy.
  task automatic run_op(input logic [63:0] sm_i, input int k_i, input int e_i,
                        input logic [1:0] m_i, input logic sg_i, input string tag,
                        input int disturb);
    ref_t r;
    int   cnt;
    r = model(sm_i, k_i, e_i, m_i);
    @(negedge clk);
    drive(sm_i, k_i, e_i, m_i, sg_i);
    start = 1'b1;
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
      if (cnt == 1) begin
        start = 1'b0;
        check({tag, " busy"}, longint'(busy), 1);
        if (disturb == 1) begin
          drive({$urandom, $urandom}, int'($urandom_range(0, 20)), int'($urandom_range(0, 7)),
                2'($urandom_range(0, 3)), ~sg_i);
          start = 1'b1;
        end
      end else if (cnt == 2) begin
        start = 1'b0;
      end
    end while (!done && cnt < 8);
    check({tag, " latency"}, longint'(cnt), 3);
    check_out(tag, r, sg_i);
    @(negedge clk);
    check({tag, " done pulse"}, longint'(done), 0);
    check({tag, " held"}, longint'(mantissa_out), r.mant);
    if (disturb == 1) check({tag, " idle"}, longint'(busy), 0);
  endtask

  // Two operations with start held through the first DONE cycle.
  task automatic run_b2b(input logic [63:0] sm_a, input logic [63:0] sm_b);
    ref_t ra, rb;
    int   cnt;
    ra = model(sm_a, 2, 7, RND_RAZ);
    rb = model(sm_b, -3, 4, RND_RNE);
    @(negedge clk);
    drive(sm_a, 2, 7, RND_RAZ, 1'b0);
    start = 1'b1;
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!done && cnt < 8);
    check("b2b first latency", longint'(cnt), 3);
    check_out("b2b first", ra, 1'b0);
    drive(sm_b, -3, 4, RND_RNE, 1'b1);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
      if (cnt == 1) begin
        start = 1'b0;
        check("b2b busy again", longint'(busy), 1);
      end
    end while (!done && cnt < 8);
    check("b2b second latency", longint'(cnt), 3);
    check_out("b2b second", rb, 1'b1);
  endtask

  // Reset asserted while the unit is in NORM.
  task automatic run_rst_mid();
    int n_done;
    @(negedge clk);
    drive(64'hFFFF_FFFF_FFFF_FFFF, 1, 7, RND_RAZ, 1'b1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_zero("rst mid");
    rst = 1'b0;
    n_done = 0;
    repeat (5) begin
      @(negedge clk);
      if (done) n_done++;
    end
    check("rst no done", longint'(n_done), 0);
  endtask

  initial begin
    logic [31:0] kept_r, tail_r;
    int          k_r, e_r;
    rst   = 1'b1;
    start = 1'b0;
    drive('0, 0, 0, RND_RNE, 1'b0);
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;

    run_op(64'hFFFF_FFFF_8000_0000, 5, 2, RND_RNE, 1'b0, "carry rne", 0);
    run_op(64'h1234_5678_8000_0000, 0, 1, RND_RNE, 1'b0, "tie rne", 0);
    run_op(64'h1234_5678_8000_0000, 0, 1, RND_RTZ, 1'b1, "tie rtz", 0);
    run_op(64'h1234_5678_8000_0000, 0, 1, RND_RAZ, 1'b0, "tie raz", 0);
    run_op(64'h1234_5678_8000_0001, 0, 1, RND_RNE, 1'b0, "above tie", 0);
    for (int m = 0; m < 4; m++)
      run_op(64'h1234_5678_0000_0000, 0, 1, 2'(m), 1'b1, "exact", 0);
    run_op('0, -4, 5, RND_RAZ, 1'b0, "zero op", 0);
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 3, 7, RND_RAZ, 1'b0, "regime carry", 0);
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 26, 7, RND_RAZ, 1'b1, "saturate", 0);
    run_op(64'hFFFF_FFFF_FFFF_FFFF, -31, 7, RND_RAZ, 1'b0, "neg regime", 0);
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 26, 6, RND_RNE, 1'b0, "kmax no sat", 0);
    run_op(64'h0000_0003_7FFF_FFFF, 1, 0, RND_RNE, 1'b0, "busy start", 1);
    run_b2b(64'hFFFF_FFFF_C000_0000, 64'h8000_0001_8000_0000);
    run_rst_mid();
    run_op(64'hABCD_0001_8000_0000, 7, 3, RND_RNE, 1'b1, "after rst", 0);

    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 2))
        0:       kept_r = 32'hFFFF_FFFF;
        default: kept_r = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0: tail_r = 32'h0;
        1: tail_r = 32'h8000_0000;
        2: tail_r = 32'h8000_0000 | 32'($urandom_range(1, 3));
        3: tail_r = 32'hFFFF_FFFF;
        4: tail_r = 32'($urandom_range(0, 3));
        default: tail_r = $urandom;
      endcase
      e_r = ($urandom_range(0, 2) == 0) ? 7 : int'($urandom_range(0, 7));
      k_r = ($urandom_range(0, 3) == 0) ? K_MAX : int'($urandom_range(0, 58)) - 32;
      run_op({kept_r, tail_r}, k_r, e_r, 2'($urandom_range(0, 3)), 1'($urandom),
             $sformatf("rand%0d", i), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
